// File: rtl/accum_cache_downstream.sv
// accum_cache_downstream: per-client saturating accumulator cache.
// Optional macro ACCUM_OVF_CNT_EN adds a 16-bit saturating count of sat_event pulses.
// Without the macro, ovf_count is tied to zero.
module accum_cache_downstream #(
  parameter int unsigned        DATA_W    = 32,
  parameter int unsigned        DEPTH     = 1024,
  parameter logic [DATA_W-1:0]  SAT_LIMIT = DATA_W'('hffaa),
  parameter int unsigned        SAT_MODE  = 0,
  localparam int unsigned       AW        = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_valid,
  output logic              acc_ready,
  input  logic [AW-1:0]     acc_idx,
  input  logic [DATA_W-1:0] acc_data,
  input  logic              rd_valid,
  input  logic [AW-1:0]     rd_idx,
  output logic              rd_data_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              sat_event,
  output logic [15:0]       ovf_count
);

  typedef enum logic [0:0] {ST_INIT, ST_RUN} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     sweep_q, sweep_d;
  logic              busy_q, busy_d;
  logic              acc_ready_q, acc_ready_d;

  logic              s1_valid_q, s1_valid_d;
  logic [AW-1:0]     s1_idx_q, s1_idx_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;

  logic              s2_valid_q, s2_valid_d;
  logic [AW-1:0]     s2_idx_q, s2_idx_d;
  logic [DATA_W-1:0] s2_data_q, s2_data_d;
  logic [DATA_W-1:0] s2_opnd_q, s2_opnd_d;

  logic              rd_data_valid_q, rd_data_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              sat_event_q, sat_event_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              acc_fire_c;
  logic              rd_fire_c;
  logic [DATA_W-1:0] s2_new_c;
  logic              s2_ovf_c;
  logic [DATA_W-1:0] s1_opnd_c;
  logic [DATA_W-1:0] s1_new_c;
  logic [DATA_W-1:0] rd_fwd_c;
  logic              mem_we_c;
  logic [AW-1:0]     mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;

  // Sum reaches the threshold; computed one bit wider so it never wraps.
  function automatic logic sat_ovf(input logic [DATA_W-1:0] opnd,
                                   input logic [DATA_W-1:0] inc);
    logic [DATA_W:0] sum;
    sum = {1'b0, opnd} + {1'b0, inc};
    return (sum >= {1'b0, SAT_LIMIT});
  endfunction

  // Value the entry takes after adding inc, applying the overflow policy.
  function automatic logic [DATA_W-1:0] sat_val(input logic [DATA_W-1:0] opnd,
                                                input logic [DATA_W-1:0] inc);
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] res;
    sum = {1'b0, opnd} + {1'b0, inc};
    if (sum >= {1'b0, SAT_LIMIT}) begin
      res = (SAT_MODE == 1) ? SAT_LIMIT : opnd;
    end else begin
      res = sum[DATA_W-1:0];
    end
    return res;
  endfunction

  // Datapath: S2 result, S1 operand forwarded from S2, read value forwarded from S1/S2.
  always_comb begin
    acc_fire_c = acc_valid && acc_ready_q;
    rd_fire_c  = rd_valid && (state_q == ST_RUN);
    s2_new_c   = sat_val(s2_opnd_q, s2_data_q);
    s2_ovf_c   = sat_ovf(s2_opnd_q, s2_data_q);
    s1_opnd_c  = (s2_valid_q && (s2_idx_q == s1_idx_q)) ? s2_new_c : mem_q[s1_idx_q];
    s1_new_c   = sat_val(s1_opnd_c, s1_data_q);
    rd_fwd_c   = mem_q[rd_idx];
    if (s2_valid_q && (s2_idx_q == rd_idx)) rd_fwd_c = s2_new_c;
    if (s1_valid_q && (s1_idx_q == rd_idx)) rd_fwd_c = s1_new_c;
  end

  // Single write port: zero sweep during INIT, S2 writeback during RUN.
  always_comb begin
    mem_we_c    = 1'b0;
    mem_addr_c  = s2_idx_q;
    mem_wdata_c = s2_new_c;
    if (state_q == ST_INIT) begin
      mem_we_c    = 1'b1;
      mem_addr_c  = sweep_q;
      mem_wdata_c = '0;
    end else if (s2_valid_q) begin
      mem_we_c    = 1'b1;
    end
  end

  // Next-state: controller, pipeline stages, read port and event pulse.
  always_comb begin
    state_d         = state_q;
    sweep_d         = sweep_q;
    busy_d          = busy_q;
    acc_ready_d     = acc_ready_q;
    s1_valid_d      = acc_fire_c;
    s1_idx_d        = s1_idx_q;
    s1_data_d       = s1_data_q;
    s2_valid_d      = s1_valid_q;
    s2_idx_d        = s2_idx_q;
    s2_data_d       = s2_data_q;
    s2_opnd_d       = s2_opnd_q;
    rd_data_valid_d = rd_fire_c;
    rd_data_d       = rd_data_q;
    sat_event_d     = s2_valid_q && s2_ovf_c;

    case (state_q)
      ST_INIT: begin
        sweep_d = sweep_q + AW'(1);
        if (sweep_q == AW'(DEPTH - 1)) begin
          state_d     = ST_RUN;
          sweep_d     = '0;
          busy_d      = 1'b0;
          acc_ready_d = 1'b1;
        end
      end
      default: begin
        busy_d      = 1'b0;
        acc_ready_d = 1'b1;
      end
    endcase

    if (acc_fire_c) begin
      s1_idx_d  = acc_idx;
      s1_data_d = acc_data;
    end
    if (s1_valid_q) begin
      s2_idx_d  = s1_idx_q;
      s2_data_d = s1_data_q;
      s2_opnd_d = s1_opnd_c;
    end
    if (rd_fire_c) rd_data_d = rd_fwd_c;
  end

  // Control and pipeline registers; reset discards in-flight accumulates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_INIT;
      sweep_q         <= '0;
      busy_q          <= 1'b1;
      acc_ready_q     <= 1'b0;
      s1_valid_q      <= 1'b0;
      s1_idx_q        <= '0;
      s1_data_q       <= '0;
      s2_valid_q      <= 1'b0;
      s2_idx_q        <= '0;
      s2_data_q       <= '0;
      s2_opnd_q       <= '0;
      rd_data_valid_q <= 1'b0;
      rd_data_q       <= '0;
      sat_event_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      sweep_q         <= sweep_d;
      busy_q          <= busy_d;
      acc_ready_q     <= acc_ready_d;
      s1_valid_q      <= s1_valid_d;
      s1_idx_q        <= s1_idx_d;
      s1_data_q       <= s1_data_d;
      s2_valid_q      <= s2_valid_d;
      s2_idx_q        <= s2_idx_d;
      s2_data_q       <= s2_data_d;
      s2_opnd_q       <= s2_opnd_d;
      rd_data_valid_q <= rd_data_valid_d;
      rd_data_q       <= rd_data_d;
      sat_event_q     <= sat_event_d;
    end
  end

  // Entry storage; contents are established by the INIT sweep, not by reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem_q[mem_addr_c] <= mem_wdata_c;
  end

`ifdef ACCUM_OVF_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  // Count saturating accumulates, sticking at all-ones.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (sat_event_d && (ovf_cnt_q != 16'hffff)) ovf_cnt_d = ovf_cnt_q + 16'd1;
  end

  // Overflow counter register, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_cnt_q <= '0;
    else     ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_count = ovf_cnt_q;
`else
  assign ovf_count = '0;
`endif

  assign acc_ready     = acc_ready_q;
  assign busy          = busy_q;
  assign rd_data_valid = rd_data_valid_q;
  assign rd_data       = rd_data_q;
  assign sat_event     = sat_event_q;

endmodule

// File: tb/tb_accum_cache_downstream.sv
// Directed bench: one instance per overflow policy, driven with identical stimulus.
module tb_accum_cache_downstream;

  localparam int unsigned DW  = 32;
  localparam int unsigned DEP = 16;
  localparam int unsigned AW  = 4;
`ifdef ACCUM_OVF_CNT_EN
  localparam int unsigned OVF_EN = 1;
`else
  localparam int unsigned OVF_EN = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          acc_valid;
  logic [AW-1:0] acc_idx;
  logic [DW-1:0] acc_data;
  logic          rd_valid;
  logic [AW-1:0] rd_idx;

  logic          acc_ready_0, rd_data_valid_0, busy_0, sat_event_0;
  logic [DW-1:0] rd_data_0;
  logic [15:0]   ovf_count_0;
  logic          acc_ready_1, rd_data_valid_1, busy_1, sat_event_1;
  logic [DW-1:0] rd_data_1;
  logic [15:0]   ovf_count_1;

  int checks   = 0;
  int failures = 0;

  accum_cache_downstream #(.DATA_W(DW), .DEPTH(DEP), .SAT_LIMIT(32'hffaa), .SAT_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .acc_valid(acc_valid), .acc_ready(acc_ready_0), .acc_idx(acc_idx), .acc_data(acc_data),
    .rd_valid(rd_valid), .rd_idx(rd_idx),
    .rd_data_valid(rd_data_valid_0), .rd_data(rd_data_0),
    .busy(busy_0), .sat_event(sat_event_0), .ovf_count(ovf_count_0)
  );

  accum_cache_downstream #(.DATA_W(DW), .DEPTH(DEP), .SAT_LIMIT(32'hffaa), .SAT_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .acc_valid(acc_valid), .acc_ready(acc_ready_1), .acc_idx(acc_idx), .acc_data(acc_data),
    .rd_valid(rd_valid), .rd_idx(rd_idx),
    .rd_data_valid(rd_data_valid_1), .rd_data(rd_data_1),
    .busy(busy_1), .sat_event(sat_event_1), .ovf_count(ovf_count_1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic acc_one(input logic [AW-1:0] idx, input logic [DW-1:0] data);
    acc_valid = 1'b1;
    acc_idx   = idx;
    acc_data  = data;
    step();
    acc_valid = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [AW-1:0] idx,
                        input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    rd_valid = 1'b1;
    rd_idx   = idx;
    step();
    rd_valid = 1'b0;
    check({tag, "_v0"}, 32'(rd_data_valid_0), 32'd1);
    check({tag, "_d0"}, rd_data_0, e0);
    check({tag, "_v1"}, 32'(rd_data_valid_1), 32'd1);
    check({tag, "_d1"}, rd_data_1, e1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    check({tag, "_busy0"},  32'(busy_0), 32'd1);
    check({tag, "_busy1"},  32'(busy_1), 32'd1);
    check({tag, "_rdy0"},   32'(acc_ready_0), 32'd0);
    check({tag, "_rdy1"},   32'(acc_ready_1), 32'd0);
    check({tag, "_rdv0"},   32'(rd_data_valid_0), 32'd0);
    check({tag, "_rdd0"},   rd_data_0, 32'd0);
    check({tag, "_rdd1"},   rd_data_1, 32'd0);
    check({tag, "_sat0"},   32'(sat_event_0), 32'd0);
    check({tag, "_sat1"},   32'(sat_event_1), 32'd0);
    check({tag, "_ovf0"},   32'(ovf_count_0), 32'd0);
    check({tag, "_ovf1"},   32'(ovf_count_1), 32'd0);
  endtask

  // Count busy cycles after reset release, bounded.
  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (busy_0 && n < 100) begin
      step();
      n++;
    end
    check({tag, "_cycles"}, 32'(n), 32'd16);
    check({tag, "_busy1"},  32'(busy_1), 32'd0);
    check({tag, "_rdy0"},   32'(acc_ready_0), 32'd1);
    check({tag, "_rdy1"},   32'(acc_ready_1), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    acc_valid = 1'b0;
    acc_idx   = '0;
    acc_data  = '0;
    rd_valid  = 1'b0;
    rd_idx    = '0;
    step();
    step();
    chk_reset_outputs("por");
    rst = 1'b0;
    wait_init("init");

    // Back-to-back accumulates to one index, reads with both pending.
    acc_valid = 1'b1;
    acc_idx   = 4'd5;
    acc_data  = 32'd10;
    step();
    acc_data  = 32'd20;
    step();
    acc_valid = 1'b0;
    rd_chk("b2b_rd_a", 4'd5, 32'd30, 32'd30);
    rd_chk("b2b_rd_b", 4'd5, 32'd30, 32'd30);
    step();
    check("hold_v0", 32'(rd_data_valid_0), 32'd0);
    check("hold_d0", rd_data_0, 32'd30);

    // Same-cycle accumulate and read: read excludes it, next read includes it.
    acc_one(4'd7, 32'd9);
    step();
    step();
    step();
    acc_valid = 1'b1;
    acc_idx   = 4'd7;
    acc_data  = 32'd4;
    rd_valid  = 1'b1;
    rd_idx    = 4'd7;
    step();
    acc_valid = 1'b0;
    check("same_cyc_d0", rd_data_0, 32'd9);
    check("same_cyc_d1", rd_data_1, 32'd9);
    rd_chk("next_cyc", 4'd7, 32'd13, 32'd13);

    // Load idx 3 below the limit: no event.
    acc_one(4'd3, 32'hff00);
    step();
    step();
    check("load_sat0", 32'(sat_event_0), 32'd0);
    check("load_sat1", 32'(sat_event_1), 32'd0);
    step();

    // Overflowing accumulate: both policies pulse exactly once.
    acc_one(4'd3, 32'hb0);
    step();
    check("ovf1_pre0", 32'(sat_event_0), 32'd0);
    step();
    check("ovf1_sat0", 32'(sat_event_0), 32'd1);
    check("ovf1_sat1", 32'(sat_event_1), 32'd1);
    step();
    check("ovf1_post0", 32'(sat_event_0), 32'd0);
    check("ovf1_post1", 32'(sat_event_1), 32'd0);
    rd_chk("ovf1_entry", 4'd3, 32'hff00, 32'hffaa);
    check("ovf1_cnt0", 32'(ovf_count_0), 32'(OVF_EN));
    check("ovf1_cnt1", 32'(ovf_count_1), 32'(OVF_EN));

    // +1: drop policy now fits under the limit, clamp policy overflows again.
    acc_one(4'd3, 32'd1);
    step();
    step();
    check("ovf2_sat0", 32'(sat_event_0), 32'd0);
    check("ovf2_sat1", 32'(sat_event_1), 32'd1);
    step();
    check("ovf2_post1", 32'(sat_event_1), 32'd0);
    rd_chk("ovf2_entry", 4'd3, 32'hff01, 32'hffaa);
    check("ovf2_cnt0", 32'(ovf_count_0), 32'(OVF_EN));
    check("ovf2_cnt1", 32'(ovf_count_1), 32'(2 * OVF_EN));

    // Mid-run reset with an accumulate in flight; everything reads back zero.
    acc_valid = 1'b1;
    acc_idx   = 4'd2;
    acc_data  = 32'd5;
    step();
    rst = 1'b1;
    step();
    acc_valid = 1'b0;
    chk_reset_outputs("mid_rst");
    rst = 1'b0;
    wait_init("reinit");
    for (int i = 0; i < 16; i++) begin
      rd_chk($sformatf("clr%0d", i), 4'(i), 32'd0, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
